ddr_sim_responder: RTL and testbench



---
 rtl/ddr_sim_responder_pkg.sv | 44 ++++
 rtl/ddr_sim_responder_if.sv | 40 ++++
 rtl/ddr_sim_responder_sim_word_ram.sv | 30 +++
 rtl/ddr_sim_responder.sv | 176 +++++++++++++++++
 tb/tb_ddr_sim_responder.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/ddr_sim_responder_pkg.sv
// Shared definitions for the simulation-side DDR responder: FSM state
// encoding, bus geometry, default address map and address translation.
package ddr_sim_responder_pkg;

  // Bus geometry: one request moves either a single 64-bit word or a
  // 512-bit line made of eight consecutive words.
  localparam int BEATS_PER_LINE = 8;
  localparam int WORD_BITS      = 64;
  localparam int LINE_BITS      = 512;
  localparam int BEAT_IDX_BITS  = 3;

  // Byte address that maps onto word 0 of the model.
  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;

  // Responder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BEAT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Data-bus operation types, shared with the arbiter side.
  typedef enum logic {
    DBUS_READ  = 1'b0,
    DBUS_WRITE = 1'b1
  } dbus_op_t;

  // Everything about a request that is needed after the capture cycle.
  typedef struct packed {
    dbus_op_t               op;
    logic                   burst;
    logic [LINE_BITS-1:0]   mask;
    logic [LINE_BITS-1:0]   data;
  } request_t;

  // Byte address to 64-bit word offset relative to the base; the caller
  // truncates to its memory depth, so out-of-range addresses wrap.
  function automatic logic [63:0] byte_to_word(input logic [63:0] index,
                                               input logic [63:0] base);
    return (index - base) >> 3;
  endfunction

endpackage

// File: rtl/ddr_sim_responder_if.sv
// Arbiter-to-DDR request interface. The arbiter drives the request side
// (master); the memory model answers on the response side (slave).
interface ddr_sim_responder_if;
  import ddr_sim_responder_pkg::*;

  logic                 ddr_chip_enable;
  logic [63:0]          ddr_index;
  logic                 ddr_write_enable;
  logic                 ddr_burst_mode;
  logic [LINE_BITS-1:0] ddr_write_mask;
  logic [LINE_BITS-1:0] ddr_write_data;
  logic [LINE_BITS-1:0] ddr_read_data;
  logic                 ddr_operation_done;
  logic                 ddr_ready;

  modport master (
    output ddr_chip_enable,
    output ddr_index,
    output ddr_write_enable,
    output ddr_burst_mode,
    output ddr_write_mask,
    output ddr_write_data,
    input  ddr_read_data,
    input  ddr_operation_done,
    input  ddr_ready
  );

  modport slave (
    input  ddr_chip_enable,
    input  ddr_index,
    input  ddr_write_enable,
    input  ddr_burst_mode,
    input  ddr_write_mask,
    input  ddr_write_data,
    output ddr_read_data,
    output ddr_operation_done,
    output ddr_ready
  );

endinterface

// File: rtl/ddr_sim_responder_sim_word_ram.sv
// Single-port 64-bit word RAM with bit-granular write mask and a
// registered (synchronous) read port. Depth is 2**ADDR_WIDTH words.
module sim_word_ram
  import ddr_sim_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  write_en,
  input  logic [WORD_BITS-1:0]  write_mask,
  input  logic [WORD_BITS-1:0]  write_data,
  output logic [WORD_BITS-1:0]  read_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WORD_BITS-1:0] mem [DEPTH];

  // Masked write and registered read on the same address every cycle.
  // NOTE: the array has no reset branch on purpose; contents survive a
  // reset and a reset loop over the whole array would not map to a RAM.
  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[addr] <= (mem[addr] & ~write_mask) | (write_data & write_mask);
    end
    read_data <= mem[addr];
  end

endmodule

// File: rtl/ddr_sim_responder.sv
// Simulation-side DDR memory model: accepts one request at a time from the
// arbiter, waits LATENCY cycles, then performs one 64-bit beat per cycle
// (8 for a line, 1 for a word) against sim_word_ram and signals completion
// with a one-cycle ddr_operation_done.
//
// The RAM read port is registered, so read addresses are issued one cycle
// ahead of the beat that consumes them: beat 0 is addressed during the last
// WAIT cycle (or the capture cycle when LATENCY is 0) and beat k+1 during
// beat k. This keeps done at T+LATENCY+NBEATS+1 for capture at cycle T.
module ddr_sim_responder
  import ddr_sim_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter int          LATENCY    = 4,
  parameter logic [63:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input logic                 clock,
  input logic                 reset_n,
  ddr_sim_responder_if.slave  ddr
);

  localparam int LAT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  state_t                    state;
  request_t                  req;
  logic [ADDR_WIDTH-1:0]     req_base;
  logic [LAT_W-1:0]          lat_cnt;
  logic [BEAT_IDX_BITS-1:0]  beat_cnt;
  logic [LINE_BITS-1:0]      asm_line;
  logic [LINE_BITS-1:0]      read_data_q;
  logic                      done_q;
  logic                      ready_q;
  logic                      ce_prev;

  logic [63:0]               in_word;
  logic [ADDR_WIDTH-1:0]     in_addr;
  logic [ADDR_WIDTH-1:0]     in_base;
  logic                      accept;
  logic [BEAT_IDX_BITS-1:0]  lane;
  logic                      last_beat;
  logic [LINE_BITS-1:0]      next_line;

  logic [ADDR_WIDTH-1:0]     ram_addr;
  logic                      ram_we;
  logic [WORD_BITS-1:0]      ram_wmask;
  logic [WORD_BITS-1:0]      ram_wdata;
  logic [WORD_BITS-1:0]      ram_rdata;
  logic                      unused_word_hi;

  // Address translation of the live request; upper word bits wrap away.
  assign in_word        = byte_to_word(ddr.ddr_index, BASE_ADDR);
  assign in_addr        = in_word[ADDR_WIDTH-1:0];
  assign unused_word_hi = ^in_word[63:ADDR_WIDTH];
  assign in_base        = ddr.ddr_burst_mode
                          ? {in_addr[ADDR_WIDTH-1:BEAT_IDX_BITS], {BEAT_IDX_BITS{1'b0}}}
                          : in_addr;

  // Only a fresh rising strobe seen in IDLE starts a request; a strobe held
  // across the DONE-to-IDLE edge is not a new request.
  assign accept = (state == ST_IDLE) && ddr.ddr_chip_enable && !ce_prev;

  // Data lane of the current beat; single-word requests always use lane 0.
  assign lane      = req.burst ? beat_cnt : '0;
  assign last_beat = !req.burst || (beat_cnt == BEAT_IDX_BITS'(BEATS_PER_LINE - 1));

  // Assembly line with the current beat's read word merged into its lane.
  // NOTE: next_line is given its full default before the lane overwrite,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_line = asm_line;
    next_line[lane*WORD_BITS +: WORD_BITS] = ram_rdata;
  end

  // RAM address: live request while idle, captured base while waiting,
  // current beat for writes and one beat ahead for reads.
  always_comb begin
    ram_addr = req_base;
    unique case (state)
      ST_IDLE: ram_addr = in_base;
      ST_BEAT: begin
        if (req.op == DBUS_WRITE) begin
          ram_addr = req_base | ADDR_WIDTH'(beat_cnt);
        end else begin
          ram_addr = req_base | ADDR_WIDTH'(beat_cnt + 3'd1);
        end
      end
      default: ram_addr = req_base;
    endcase
  end

  // Write port driven only from the captured request during BEAT.
  assign ram_we    = (state == ST_BEAT) && (req.op == DBUS_WRITE);
  assign ram_wmask = req.mask[lane*WORD_BITS +: WORD_BITS];
  assign ram_wdata = req.data[lane*WORD_BITS +: WORD_BITS];

  sim_word_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clock      (clock),
    .addr       (ram_addr),
    .write_en   (ram_we),
    .write_mask (ram_wmask),
    .write_data (ram_wdata),
    .read_data  (ram_rdata)
  );

  // Request FSM with registered ready/done/read_data outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      req         <= '0;
      req_base    <= '0;
      lat_cnt     <= '0;
      beat_cnt    <= '0;
      asm_line    <= '0;
      read_data_q <= '0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
      ce_prev     <= 1'b0;
    end else begin
      ce_prev <= ddr.ddr_chip_enable;
      done_q  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            req.op    <= ddr.ddr_write_enable ? DBUS_WRITE : DBUS_READ;
            req.burst <= ddr.ddr_burst_mode;
            req.mask  <= ddr.ddr_write_mask;
            req.data  <= ddr.ddr_write_data;
            req_base  <= in_base;
            lat_cnt   <= LAT_W'(LATENCY);
            beat_cnt  <= '0;
            asm_line  <= '0;
            ready_q   <= 1'b0;
            if (LATENCY == 0) begin
              state <= ST_BEAT;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt <= LAT_W'(1)) begin
            state <= ST_BEAT;
          end
        end
        ST_BEAT: begin
          if (req.op == DBUS_READ) begin
            asm_line <= next_line;
          end
          beat_cnt <= beat_cnt + 3'd1;
          if (last_beat) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
            if (req.op == DBUS_READ) begin
              read_data_q <= next_line;
            end
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ddr.ddr_read_data      = read_data_q;
  assign ddr.ddr_operation_done = done_q;
  assign ddr.ddr_ready          = ready_q;

endmodule

// File: tb/tb_ddr_sim_responder.sv
// Testbench for ddr_sim_responder: dut_a (16 words, LATENCY 4) covers
// bursts, masking, busy rejection, wrap and reset abort; dut_b (LATENCY 0)
// covers zero-latency timing and a held strobe. A monitor per DUT pops the
// expected read_data from a queue on every done pulse.
module tb_ddr_sim_responder;
  import ddr_sim_responder_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  logic [511:0] q_a[$];
  logic [511:0] q_b[$];
  logic [511:0] last_rd [2];
  logic         prev_done_a = 1'b0;
  logic         prev_done_b = 1'b0;
  logic [1:0]   done_v;
  logic [1:0]   ready_v;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  ddr_sim_responder_if ifa();
  ddr_sim_responder_if ifb();

  ddr_sim_responder #(.ADDR_WIDTH(4), .LATENCY(4), .BASE_ADDR(64'h8000_0000)) dut_a (
    .clock(clock), .reset_n(reset_n), .ddr(ifa));
  ddr_sim_responder #(.ADDR_WIDTH(16), .LATENCY(0), .BASE_ADDR(64'h8000_0000)) dut_b (
    .clock(clock), .reset_n(reset_n), .ddr(ifb));

  assign done_v  = {ifb.ddr_operation_done, ifa.ddr_operation_done};
  assign ready_v = {ifb.ddr_ready, ifa.ddr_ready};

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input bit ce, input bit we, input bit burst,
                       input logic [63:0] idx, input logic [511:0] mask,
                       input logic [511:0] data);
    if (sel == 0) begin
      ifa.ddr_chip_enable = ce; ifa.ddr_write_enable = we; ifa.ddr_burst_mode = burst;
      ifa.ddr_index = idx; ifa.ddr_write_mask = mask; ifa.ddr_write_data = data;
    end else begin
      ifb.ddr_chip_enable = ce; ifb.ddr_write_enable = we; ifb.ddr_burst_mode = burst;
      ifb.ddr_index = idx; ifb.ddr_write_mask = mask; ifb.ddr_write_data = data;
    end
  endtask

  // Issue one request, push its expected read_data and check its timing.
  // exp_lat = LATENCY + NBEATS: done is seen that many cycles after ready drops.
  task automatic run_op(input int sel, input bit we, input bit burst, input logic [63:0] idx,
                        input logic [511:0] mask, input logic [511:0] data,
                        input logic [511:0] exp_rd, input int exp_lat, input bit rogue,
                        input string tag);
    int c0;
    int n;
    if (!we) last_rd[sel] = exp_rd;
    if (sel == 0) q_a.push_back(last_rd[sel]); else q_b.push_back(last_rd[sel]);
    @(negedge clock);
    drive(sel, 1'b1, we, burst, idx, mask, data);
    @(negedge clock);
    c0 = cyc;
    drive(sel, 1'b0, we, burst, idx, mask, data);
    check({tag, "_ready_low"}, 512'(ready_v[sel]), 512'd0);
    n = 0;
    while (!done_v[sel] && n < 64) begin
      @(negedge clock);
      n++;
      if (rogue && n == 1)
        drive(sel, 1'b1, 1'b1, 1'b0, 64'h8000_0010, '1, {8{64'h5555_5555_5555_5555}});
      if (rogue && n == 2)
        drive(sel, 1'b0, 1'b1, 1'b0, 64'h8000_0010, '1, {8{64'h5555_5555_5555_5555}});
    end
    check({tag, "_done_cycle"}, 512'(n), 512'(exp_lat));
    check({tag, "_ready_at_done"}, 512'(ready_v[sel]), 512'd0);
    @(negedge clock);
    check({tag, "_done_one_cycle"}, 512'(done_v[sel]), 512'd0);
    check({tag, "_ready_back"}, 512'(ready_v[sel]), 512'd1);
  endtask

  // Scoreboard monitor for dut_a.
  always @(negedge clock) begin
    if (ifa.ddr_operation_done) begin
      check("done_width_a", 512'(prev_done_a), 512'd0);
      if (q_a.size() == 0) check("pending_a", 512'(q_a.size()), 512'd1);
      else check("rdata_a", ifa.ddr_read_data, q_a.pop_front());
    end
    prev_done_a <= ifa.ddr_operation_done;
  end

  // Scoreboard monitor for dut_b.
  always @(negedge clock) begin
    if (ifb.ddr_operation_done) begin
      check("done_width_b", 512'(prev_done_b), 512'd0);
      if (q_b.size() == 0) check("pending_b", 512'(q_b.size()), 512'd1);
      else check("rdata_b", ifb.ddr_read_data, q_b.pop_front());
    end
    prev_done_b <= ifb.ddr_operation_done;
  end

  initial begin
    logic [511:0] line1;
    logic [511:0] line_new;
    logic [63:0]  w;
    int           c0;

    for (int k = 0; k < 8; k++) line1[64*k +: 64] = 64'h1111_1111_1111_1111 * 64'(k + 1);
    line_new   = {8{64'hCAFE_CAFE_CAFE_CAFE}};
    last_rd[0] = '0;
    last_rd[1] = '0;
    drive(0, 1'b0, 1'b0, 1'b0, 64'h0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, 64'h0, '0, '0);

    // Reset values
    #12;
    check("reset_ready_a", 512'(ifa.ddr_ready), 512'd1);
    check("reset_done_a", 512'(ifa.ddr_operation_done), 512'd0);
    check("reset_rdata_a", ifa.ddr_read_data, 512'd0);
    check("reset_ready_b", 512'(ifb.ddr_ready), 512'd1);
    @(negedge clock);
    reset_n = 1'b1;

    // Burst write then burst read at 0x8000_0040, LATENCY 4: done 12 after ready drops
    run_op(0, 1'b1, 1'b1, 64'h8000_0040, '1, line1, '0, 12, 1'b0, "burst_wr");
    run_op(0, 1'b0, 1'b1, 64'h8000_0040, '0, '0, line1, 12, 1'b0, "burst_rd");

    // Partial mask over zero
    run_op(0, 1'b1, 1'b0, 64'h8000_0000, '1, '0, '0, 5, 1'b0, "mask_clear");
    run_op(0, 1'b1, 1'b0, 64'h8000_0000, 512'h0000_0000_FFFF_0000,
           512'hFFFF_FFFF_FFFF_FFFF, '0, 5, 1'b0, "mask_wr");
    run_op(0, 1'b0, 1'b0, 64'h8000_0000, '0, '0, 512'h0000_0000_FFFF_0000, 5, 1'b0, "mask_rd");

    // Busy rejection: stray strobe to word 2 during WAIT must be dropped
    run_op(0, 1'b1, 1'b0, 64'h8000_0010, '1, '0, '0, 5, 1'b0, "busy_clear");
    run_op(0, 1'b1, 1'b0, 64'h8000_0008, '1, 512'hAAAA_AAAA_AAAA_AAAA, '0, 5, 1'b1, "busy_wr");
    run_op(0, 1'b0, 1'b0, 64'h8000_0010, '0, '0, 512'd0, 5, 1'b0, "busy_rd_w2");
    run_op(0, 1'b0, 1'b0, 64'h8000_0008, '0, '0, 512'hAAAA_AAAA_AAAA_AAAA, 5, 1'b0, "busy_rd_w1");

    // Address wrap with 16 words: word 16 aliases word 0
    run_op(0, 1'b1, 1'b0, 64'h8000_0080, '1, 512'h0123_4567_89AB_CDEF, '0, 5, 1'b0, "wrap_wr");
    run_op(0, 1'b0, 1'b0, 64'h8000_0000, '0, '0, 512'h0123_4567_89AB_CDEF, 5, 1'b0, "wrap_rd");

    // Reset during beat 3 of a burst write over line1
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 1'b1, 64'h8000_0040, '1, line_new);
    @(negedge clock);
    c0 = cyc;
    drive(0, 1'b0, 1'b1, 1'b1, 64'h8000_0040, '1, line_new);
    while (cyc < c0 + 7) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst_mid_ready", 512'(ifa.ddr_ready), 512'd1);
    check("rst_mid_done", 512'(ifa.ddr_operation_done), 512'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k != 3) begin
        w = (k < 3) ? 64'hCAFE_CAFE_CAFE_CAFE : 64'h1111_1111_1111_1111 * 64'(k + 1);
        run_op(0, 1'b0, 1'b0, 64'h8000_0040 + 64'(8 * k), '0, '0, 512'(w), 5, 1'b0, "rst_word");
      end
    end

    // LATENCY 0: single write/read (done 1 cycle after ready drops), bursts (8)
    run_op(1, 1'b1, 1'b0, 64'h8000_0018, '1, 512'h0F0F_0F0F_0F0F_0F0F, '0, 1, 1'b0, "l0_wr");
    run_op(1, 1'b0, 1'b0, 64'h8000_0018, '0, '0, 512'h0F0F_0F0F_0F0F_0F0F, 1, 1'b0, "l0_rd");
    run_op(1, 1'b1, 1'b1, 64'h8000_0100, '1, line1, '0, 8, 1'b0, "l0_burst_wr");
    run_op(1, 1'b0, 1'b1, 64'h8000_0108, '0, '0, line1, 8, 1'b0, "l0_burst_rd");

    // Strobe held high across DONE-to-IDLE: exactly one request accepted
    last_rd[1] = 512'h0F0F_0F0F_0F0F_0F0F;
    q_b.push_back(last_rd[1]);
    @(negedge clock);
    drive(1, 1'b1, 1'b0, 1'b0, 64'h8000_0018, '0, '0);
    repeat (5) @(negedge clock);
    drive(1, 1'b0, 1'b0, 1'b0, 64'h8000_0018, '0, '0);
    repeat (6) @(negedge clock);
    check("held_ce_one_done", 512'(q_b.size()), 512'd0);

    repeat (4) @(negedge clock);
    check("queue_a_drained", 512'(q_a.size()), 512'd0);
    check("queue_b_drained", 512'(q_b.size()), 512'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
